// File: rtl/control_sequencer.sv
`default_nettype none
// control_sequencer: hardwired control unit driving every DataPath strobe through fetch, decode and execute.
// Rev 1.0
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00000,
  parameter logic [4:0] ALU_AND = 5'b00010,
  parameter logic [4:0] ALU_OR  = 5'b00011
) (
  input  logic        Clock,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        PC_out, ZHigh_out, ZLow_out, HI_out, LO_out,
  output logic        C_out, MDR_out, in_port_out, BA_out, R_out,
  output logic        MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable,
  output logic        PC_enable, HI_enable, LO_enable, R_in,
  output logic        Gra, Grb, Grc,
  output logic        IncPC, Read, RAM_write_enable, out_port_enable, con_in,
  output logic [4:0]  opcode,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     r_state;
  logic [4:0] w_op;
  logic       w_rtype, w_imm, w_mem, w_st, w_muldiv, w_branch, w_halt_op, w_last;
  logic       w_unused_ir;

  assign w_op        = IR[31:27];
  assign w_unused_ir = ^IR[26:0];
  assign w_rtype     = (w_op <= 5'b00111);
  assign w_imm       = (w_op == 5'b01000) || (w_op == 5'b01001) || (w_op == 5'b01010);
  assign w_mem       = (w_op == 5'b01011) || (w_op == 5'b01100);
  assign w_st        = (w_op == 5'b01100);
  assign w_muldiv    = (w_op == 5'b01101) || (w_op == 5'b01110);
  assign w_branch    = (w_op == 5'b10001);
  assign w_halt_op   = (w_op == 5'b10110);

  // Final execute step of the current instruction class
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_T3:    w_last = !(w_rtype || w_imm || w_mem || w_muldiv || w_branch);
      S_T5:    w_last = w_rtype || w_imm;
      S_T6:    w_last = w_muldiv || w_branch;
      S_T7:    w_last = w_mem;
      default: w_last = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      r_state <= S_RST;
    end else if (w_last) begin
      r_state <= (Stop || w_halt_op) ? S_HALT : S_T0;
    end else begin
      case (r_state)
        S_RST:   r_state <= S_T0;
        S_T0:    r_state <= S_T1;
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= S_T4;
        S_T4:    r_state <= S_T5;
        S_T5:    r_state <= S_T6;
        S_T6:    r_state <= S_T7;
        S_T7:    r_state <= S_T0;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
    end
  end

  // Strobes decode from the state register; IR is loaded on the edge entering T3,
  // so execute-step strobes cannot be precomputed a cycle early.
  always_comb begin
    PC_out = 1'b0; ZHigh_out = 1'b0; ZLow_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
    C_out = 1'b0; MDR_out = 1'b0; in_port_out = 1'b0; BA_out = 1'b0; R_out = 1'b0;
    MAR_enable = 1'b0; MDR_enable = 1'b0; IR_enable = 1'b0; Y_enable = 1'b0; Z_enable = 1'b0;
    PC_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0; R_in = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; RAM_write_enable = 1'b0; out_port_enable = 1'b0; con_in = 1'b0;
    opcode = 5'b00000;
    Run = (r_state != S_RST) && (r_state != S_HALT);
    case (r_state)
      S_T0: begin PC_out = 1'b1; MAR_enable = 1'b1; end
      S_T1: begin Read = 1'b1; MDR_enable = 1'b1; end
      S_T2: begin MDR_out = 1'b1; IR_enable = 1'b1; PC_enable = 1'b1; IncPC = 1'b1; end
      S_T3: begin
        if (w_rtype || w_imm) begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        else if (w_mem) begin Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1; end
        else if (w_muldiv) begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        else begin
          case (w_op)
            5'b01111: begin HI_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            5'b10000: begin LO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            5'b10001: begin Gra = 1'b1; R_out = 1'b1; con_in = 1'b1; end
            5'b10010: begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
            5'b10011: begin in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            5'b10100: begin Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (w_rtype || w_muldiv) begin
          Grc = w_rtype; Grb = w_muldiv; R_out = 1'b1; opcode = w_op; Z_enable = 1'b1;
        end else if (w_imm || w_mem) begin
          C_out = 1'b1; Z_enable = 1'b1;
          opcode = (w_op == 5'b01001) ? ALU_AND : (w_op == 5'b01010) ? ALU_OR : ALU_ADD;
        end else if (w_branch) begin
          PC_out = 1'b1; Y_enable = 1'b1;
        end
      end
      S_T5: begin
        if (w_rtype || w_imm) begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        else if (w_mem) begin ZLow_out = 1'b1; MAR_enable = 1'b1; end
        else if (w_muldiv) begin ZLow_out = 1'b1; LO_enable = 1'b1; end
        else if (w_branch) begin C_out = 1'b1; opcode = ALU_ADD; Z_enable = 1'b1; end
      end
      S_T6: begin
        if (w_mem && !w_st) begin Read = 1'b1; MDR_enable = 1'b1; end
        else if (w_st) begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
        else if (w_muldiv) begin ZHigh_out = 1'b1; HI_enable = 1'b1; end
        else if (w_branch) begin ZLow_out = 1'b1; PC_enable = CON; end
      end
      S_T7: begin
        if (w_st) RAM_write_enable = 1'b1;
        else if (w_mem) begin MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer: directed stimulus with a queue-based scoreboard checking control strobes.
// Rev 1.0
module tb_control_sequencer;

  logic        Clock, clr, CON, Stop;
  logic [31:0] IR;
  logic PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out, R_out;
  logic MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable, HI_enable, LO_enable, R_in;
  logic Gra, Grb, Grc, IncPC, Read, RAM_write_enable, out_port_enable, con_in, Run;
  logic [4:0] opcode;

  control_sequencer dut (
    .Clock(Clock), .clr(clr), .IR(IR), .CON(CON), .Stop(Stop),
    .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out), .LO_out(LO_out),
    .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out), .BA_out(BA_out), .R_out(R_out),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
    .Z_enable(Z_enable), .PC_enable(PC_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .R_in(R_in), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
    .RAM_write_enable(RAM_write_enable), .out_port_enable(out_port_enable), .con_in(con_in),
    .opcode(opcode), .Run(Run)
  );

  localparam logic [32:0] M_PC_OUT  = 33'd1 << 32, M_ZHIGH  = 33'd1 << 31, M_ZLOW   = 33'd1 << 30;
  localparam logic [32:0] M_HI_OUT  = 33'd1 << 29, M_LO_OUT = 33'd1 << 28, M_C_OUT  = 33'd1 << 27;
  localparam logic [32:0] M_MDR_OUT = 33'd1 << 26, M_IN_OUT = 33'd1 << 25, M_BA_OUT = 33'd1 << 24;
  localparam logic [32:0] M_R_OUT   = 33'd1 << 23, M_MAR    = 33'd1 << 22, M_MDR_EN = 33'd1 << 21;
  localparam logic [32:0] M_IR_EN   = 33'd1 << 20, M_Y_EN   = 33'd1 << 19, M_Z_EN   = 33'd1 << 18;
  localparam logic [32:0] M_PC_EN   = 33'd1 << 17, M_HI_EN  = 33'd1 << 16, M_LO_EN  = 33'd1 << 15;
  localparam logic [32:0] M_R_IN    = 33'd1 << 14, M_GRA    = 33'd1 << 13, M_GRB    = 33'd1 << 12;
  localparam logic [32:0] M_GRC     = 33'd1 << 11, M_INCPC  = 33'd1 << 10, M_READ   = 33'd1 << 9;
  localparam logic [32:0] M_RAM_WE  = 33'd1 << 8,  M_OUTP   = 33'd1 << 7,  M_CON_IN = 33'd1 << 6;
  localparam logic [32:0] M_RUN     = 33'd1;

  function automatic logic [32:0] op_f(input logic [4:0] o);
    return {27'd0, o, 1'b0};
  endfunction

  logic [32:0] act;
  assign act = {PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out, R_out,
                MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable, HI_enable, LO_enable,
                R_in, Gra, Grb, Grc, IncPC, Read, RAM_write_enable, out_port_enable, con_in, opcode, Run};

  typedef struct { string name; logic [32:0] vec; } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  event sample_now;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Monitor: drains every expectation queued for the current cycle and compares it
  always @(negedge Clock or sample_now) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.vec) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.vec);
      end
    end
    checks++;
    if ($countones({PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out,
                    in_port_out, BA_out, R_out}) > 1) begin
      fails++;
      $display("FAIL bus_onehot: got %h expected at most one bus source", act);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [32:0] v);
    exp_t e;
    e.name = nm;
    e.vec  = v;
    sb.push_back(e);
  endtask

  // Holds clr low for n cycles, releases it, and advances into T0
  task automatic do_reset(input int n);
    clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      push_exp("reset_low", 33'd0);
    end
    clr = 1'b1;
    push_exp("reset_released", 33'd0);
    tick();
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] ir);
    push_exp({nm, " T0"}, M_PC_OUT | M_MAR | M_RUN);
    tick();
    push_exp({nm, " T1"}, M_READ | M_MDR_EN | M_RUN);
    tick();
    push_exp({nm, " T2"}, M_MDR_OUT | M_IR_EN | M_PC_EN | M_INCPC | M_RUN);
    IR = ir;
    tick();
  endtask

  task automatic run_instr(input string nm, input logic [4:0] op, input logic stop_t3, input int n,
                           input logic [32:0] s0, input logic [32:0] s1, input logic [32:0] s2,
                           input logic [32:0] s3, input logic [32:0] s4);
    logic [32:0] s [5];
    s = '{s0, s1, s2, s3, s4};
    do_fetch(nm, {op, 27'h2A5A5A5});
    if (stop_t3) Stop = 1'b1;
    for (int i = 0; i < n; i++) begin
      push_exp($sformatf("%s T%0d", nm, 3 + i), s[i] | M_RUN);
      tick();
    end
  endtask

  initial begin
    clr = 1'b1; CON = 1'b0; Stop = 1'b0; IR = 32'd0;
    #3;
    do_reset(2);

    run_instr("addi", 5'b01000, 1'b0, 3, M_GRB | M_R_OUT | M_Y_EN, M_C_OUT | M_Z_EN | op_f(5'b00000),
              M_ZLOW | M_GRA | M_R_IN, 33'd0, 33'd0);
    run_instr("ld", 5'b01011, 1'b0, 5, M_GRB | M_BA_OUT | M_Y_EN, M_C_OUT | M_Z_EN,
              M_ZLOW | M_MAR, M_READ | M_MDR_EN, M_MDR_OUT | M_GRA | M_R_IN);
    run_instr("mfhi", 5'b01111, 1'b0, 1, M_HI_OUT | M_GRA | M_R_IN, 33'd0, 33'd0, 33'd0, 33'd0);
    run_instr("or_r", 5'b00011, 1'b0, 3, M_GRB | M_R_OUT | M_Y_EN, M_GRC | M_R_OUT | M_Z_EN | op_f(5'b00011),
              M_ZLOW | M_GRA | M_R_IN, 33'd0, 33'd0);
    run_instr("andi", 5'b01001, 1'b0, 3, M_GRB | M_R_OUT | M_Y_EN, M_C_OUT | M_Z_EN | op_f(5'b00010),
              M_ZLOW | M_GRA | M_R_IN, 33'd0, 33'd0);
    run_instr("ori", 5'b01010, 1'b0, 3, M_GRB | M_R_OUT | M_Y_EN, M_C_OUT | M_Z_EN | op_f(5'b00011),
              M_ZLOW | M_GRA | M_R_IN, 33'd0, 33'd0);
    run_instr("st", 5'b01100, 1'b0, 5, M_GRB | M_BA_OUT | M_Y_EN, M_C_OUT | M_Z_EN,
              M_ZLOW | M_MAR, M_GRA | M_R_OUT | M_MDR_EN, M_RAM_WE);
    run_instr("div", 5'b01110, 1'b0, 4, M_GRA | M_R_OUT | M_Y_EN, M_GRB | M_R_OUT | M_Z_EN | op_f(5'b01110),
              M_ZLOW | M_LO_EN, M_ZHIGH | M_HI_EN, 33'd0);
    CON = 1'b1;
    run_instr("br_taken", 5'b10001, 1'b0, 4, M_GRA | M_R_OUT | M_CON_IN, M_PC_OUT | M_Y_EN,
              M_C_OUT | M_Z_EN, M_ZLOW | M_PC_EN, 33'd0);
    CON = 1'b0;
    run_instr("br_not", 5'b10001, 1'b0, 4, M_GRA | M_R_OUT | M_CON_IN, M_PC_OUT | M_Y_EN,
              M_C_OUT | M_Z_EN, M_ZLOW, 33'd0);
    run_instr("jr", 5'b10010, 1'b0, 1, M_GRA | M_R_OUT | M_PC_EN, 33'd0, 33'd0, 33'd0, 33'd0);
    run_instr("in", 5'b10011, 1'b0, 1, M_IN_OUT | M_GRA | M_R_IN, 33'd0, 33'd0, 33'd0, 33'd0);
    run_instr("out", 5'b10100, 1'b0, 1, M_GRA | M_R_OUT | M_OUTP, 33'd0, 33'd0, 33'd0, 33'd0);
    run_instr("mflo", 5'b10000, 1'b0, 1, M_LO_OUT | M_GRA | M_R_IN, 33'd0, 33'd0, 33'd0, 33'd0);
    run_instr("nop", 5'b10101, 1'b0, 1, 33'd0, 33'd0, 33'd0, 33'd0, 33'd0);
    run_instr("undef", 5'b11111, 1'b0, 1, 33'd0, 33'd0, 33'd0, 33'd0, 33'd0);

    // mul interrupted by clr during T5
    do_fetch("mul", {5'b01101, 27'h0001234});
    push_exp("mul T3", M_GRA | M_R_OUT | M_Y_EN | M_RUN);
    tick();
    push_exp("mul T4", M_GRB | M_R_OUT | M_Z_EN | op_f(5'b01101) | M_RUN);
    tick();
    push_exp("mul T5", M_ZLOW | M_LO_EN | M_RUN);
    @(negedge Clock);
    #1;
    clr = 1'b0;
    #1;
    push_exp("mul clr_async", 33'd0);
    -> sample_now;
    do_reset(1);

    // Stop held from T3 of an add: completes, then halts
    run_instr("add_stop", 5'b00000, 1'b1, 3, M_GRB | M_R_OUT | M_Y_EN, M_GRC | M_R_OUT | M_Z_EN,
              M_ZLOW | M_GRA | M_R_IN, 33'd0, 33'd0);
    push_exp("halt_after_stop", 33'd0);
    Stop = 1'b0;
    tick();
    push_exp("halt_hold", 33'd0);
    tick();
    push_exp("halt_hold2", 33'd0);
    do_reset(1);

    run_instr("halt_op", 5'b10110, 1'b0, 1, 33'd0, 33'd0, 33'd0, 33'd0, 33'd0);
    push_exp("halt_op_halted", 33'd0);
    tick();
    push_exp("halt_op_hold", 33'd0);
    do_reset(1);
    push_exp("final T0", M_PC_OUT | M_MAR | M_RUN);

    @(negedge Clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
